// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, ALU op, opcode/funct and datapath select encodings for mc_ctrl
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    ALUWB  = 4'd3,
    MEMADR = 4'd4,
    MEMRD  = 4'd5,
    MEMWB  = 4'd6,
    MEMWR  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_ABS = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_ABS  = 6'b111111;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational opcode/funct classifier for mc_ctrl
// MC_CTRL_ABS_EN enables decoding of R-type funct 111111 as abs.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_rtype,
  output logic       is_ori,
  output logic       is_lui,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_abs,
  output logic       funct_ok
);

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);

`ifdef MC_CTRL_ABS_EN
  assign is_abs = is_rtype && (funct == FN_ABS);
`else
  assign is_abs = 1'b0;
`endif

  // Anything not recognised here still retires, but as a nop without writeback.
  assign funct_ok = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) || is_abs);

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with retired-instruction counter
// MC_CTRL_ABS_EN (via mc_ctrl_decode) adds the R-type abs instruction.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ext_op,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state, next_state;
  logic   is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_abs, funct_ok;

  mc_ctrl_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .is_rtype (is_rtype),
    .is_ori   (is_ori),
    .is_lui   (is_lui),
    .is_lw    (is_lw),
    .is_sw    (is_sw),
    .is_beq   (is_beq),
    .is_j     (is_j),
    .is_abs   (is_abs),
    .funct_ok (funct_ok)
  );

  // Every path back to FETCH retires exactly one instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state == FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_op     = EXT_ZERO;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        next_state = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        ext_op    = EXT_SIGN;
        if (is_rtype || is_ori || is_lui) next_state = EXEC;
        else if (is_lw || is_sw)          next_state = MEMADR;
        else if (is_beq)                  next_state = BRANCH;
        else if (is_j)                    next_state = JUMP;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        if (is_rtype) begin
          alu_src_b = SRCB_RT;
          if (is_abs)                  alu_op = ALU_ABS;
          else if (funct == FN_SUBU)   alu_op = ALU_SUB;
          if (funct_ok) next_state = ALUWB;
        end else if (is_ori || is_lui) begin
          alu_src_b  = SRCB_IMM;
          ext_op     = is_lui ? EXT_LUI : EXT_ZERO;
          alu_op     = ALU_OR;
          next_state = ALUWB;
        end
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = is_rtype;
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        ext_op     = EXT_SIGN;
        next_state = is_sw ? MEMWR : MEMRD;
      end
      MEMRD:  next_state = MEMWB;
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR:  mem_write = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      default: next_state = FETCH;
    endcase
    // Reset must silence the datapath immediately, not at the next edge.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      ext_op     = EXT_ZERO;
      pc_src     = PCSRC_ALU;
      alu_op     = ALU_AND;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against a per-instruction step model
module tb_mc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          zero;
  logic          pc_write, ir_write, reg_write, mem_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b, ext_op, pc_src;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_cnt;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .instr_cnt  (instr_cnt)
  );

  typedef struct packed {
    logic       pc_write, ir_write, reg_write, mem_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, ext_op, pc_src;
    logic [2:0] alu_op;
  } outs_t;

  typedef enum {K_ADD, K_SUB, K_ABS, K_RNOP, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_NOP} kind_t;

  outs_t act;
  assign act = {pc_write, ir_write, reg_write, mem_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, ext_op, pc_src, alu_op};

  int    n_cmp = 0;
  int    n_bad = 0;
  int    retired = 0;
  outs_t last [0:4];
  int    cnt_at_start, mw_cycles, rw_cycles, op4_seen;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) return K_ADD;
        if (fn == 6'b100011) return K_SUB;
`ifdef MC_CTRL_ABS_EN
        if (fn == 6'b111111) return K_ABS;
`endif
        return K_RNOP;
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_LW:              return 5;
      K_RNOP, K_BEQ, K_J: return 3;
      K_NOP:             return 2;
      default:           return 4;
    endcase
  endfunction

  function automatic outs_t expect_out(input kind_t k, input int s, input logic z);
    outs_t o = '0;
    o.alu_op = 3'd2;
    if (s == 0) begin
      o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2'd1;
    end else if (s == 1) begin
      o.alu_src_b = 2'd3; o.ext_op = 2'd1;
    end else begin
      case (k)
        K_ADD, K_SUB, K_ABS, K_RNOP: begin
          if (s == 2) begin
            o.alu_src_a = 1;
            o.alu_op = (k == K_SUB) ? 3'd3 : (k == K_ABS) ? 3'd4 : 3'd2;
          end else begin
            o.reg_write = 1; o.reg_dst = 1;
          end
        end
        K_ORI, K_LUI: begin
          if (s == 2) begin
            o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 3'd1;
            o.ext_op = (k == K_LUI) ? 2'd2 : 2'd0;
          end else o.reg_write = 1;
        end
        K_LW, K_SW: begin
          if (s == 2) begin
            o.alu_src_a = 1; o.alu_src_b = 2'd2; o.ext_op = 2'd1;
          end else if (s == 3 && k == K_SW) o.mem_write = 1;
          else if (s == 4) begin
            o.reg_write = 1; o.mem_to_reg = 1;
          end
        end
        K_BEQ: begin
          o.alu_src_a = 1; o.alu_op = 3'd3; o.pc_src = 2'd1; o.pc_write = z;
        end
        K_J: begin
          o.pc_write = 1; o.pc_src = 2'd2;
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  // zmode: 0/1 force zero, 2 random; abort_step >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int abort_step);
    kind_t k   = classify(op, fn);
    int    lat = latency(k);
    mw_cycles = 0; rw_cycles = 0; op4_seen = 0;
    for (int s = 0; s < lat; s++) begin
      @(negedge clk);
      if (s == 0) begin
        reset = 1'b0; opcode = op; funct = fn;
      end
      zero = (zmode == 2) ? ($urandom_range(0, 1) == 1) : (zmode == 1);
      #1;
      if (s == 0) cnt_at_start = int'(instr_cnt);
      last[s] = act;
      mw_cycles += int'(mem_write);
      rw_cycles += int'(reg_write);
      if (alu_op == 3'd4) op4_seen++;
      chk("outputs", 32'(act), 32'(expect_out(k, s, zero)));
      chk("instr_cnt", 32'(instr_cnt), 32'(retired % (1 << CW)));
      if (s == abort_step) begin
        reset = 1'b1;
        #1;
        chk("abort_outputs", 32'(act), 32'd0);
        chk("abort_cnt", 32'(instr_cnt), 32'd0);
        retired = 0;
        return;
      end
    end
    retired++;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b000000; funct = 6'b100001; zero = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset_outputs", 32'(act), 32'd0);
      chk("reset_cnt", 32'(instr_cnt), 32'd0);
    end

    run_instr(6'b000000, 6'b100001, 2, -1);
    chk("addu_exec_alu_op", 32'(last[2].alu_op), 32'd2);
    chk("addu_wb_reg_write", 32'(last[3].reg_write), 32'd1);
    chk("addu_wb_reg_dst", 32'(last[3].reg_dst), 32'd1);

    run_instr(6'b100011, 6'd0, 2, -1);
    chk("cnt_after_addu", 32'(cnt_at_start), 32'd1);
    chk("lw_memadr_srcb", 32'(last[2].alu_src_b), 32'd2);
    chk("lw_memadr_ext", 32'(last[2].ext_op), 32'd1);
    chk("lw_memwb_m2r", 32'(last[4].mem_to_reg), 32'd1);

    run_instr(6'b101011, 6'd0, 2, -1);
    chk("sw_mem_write_cycles", 32'(mw_cycles), 32'd1);

    run_instr(6'b000100, 6'd0, 1, -1);
    chk("beq_taken_pc_write", 32'(last[2].pc_write), 32'd1);
    chk("beq_taken_pc_src", 32'(last[2].pc_src), 32'd1);
    run_instr(6'b000100, 6'd0, 0, -1);
    chk("beq_not_taken_pc_write", 32'(last[2].pc_write), 32'd0);

    run_instr(6'b001101, 6'd0, 2, -1);
    chk("cnt_after_beqs", 32'(cnt_at_start), 32'd5);
    chk("ori_alu_op", 32'(last[2].alu_op), 32'd1);
    chk("ori_ext", 32'(last[2].ext_op), 32'd0);
    chk("ori_reg_dst", 32'(last[3].reg_dst), 32'd0);
    run_instr(6'b001111, 6'd0, 2, -1);
    chk("lui_ext", 32'(last[2].ext_op), 32'd2);

    run_instr(6'b111111, 6'd0, 2, -1);
    chk("nop_writes", 32'(mw_cycles + rw_cycles), 32'd0);

    run_instr(6'b000000, 6'b111111, 2, -1);
`ifdef MC_CTRL_ABS_EN
    chk("abs_alu_op", 32'(last[2].alu_op), 32'd4);
    chk("abs_reg_write", 32'(last[3].reg_write), 32'd1);
`else
    chk("abs_off_alu_op4", 32'(op4_seen), 32'd0);
    chk("abs_off_reg_write", 32'(rw_cycles), 32'd0);
`endif

    run_instr(6'b101011, 6'd0, 2, 3);
    chk("abort_mem_write_before", 32'(last[3].mem_write), 32'd1);
    run_instr(6'b000000, 6'b100011, 2, -1);
    chk("cnt_after_abort", 32'(cnt_at_start), 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] op, fn;
      case ($urandom_range(0, 8))
        0: op = 6'b000000;
        1: op = 6'b001101;
        2: op = 6'b001111;
        3: op = 6'b100011;
        4: op = 6'b101011;
        5: op = 6'b000100;
        6: op = 6'b000010;
        7: op = 6'($urandom);
        default: op = 6'b111111;
      endcase
      case ($urandom_range(0, 3))
        0: fn = 6'b100001;
        1: fn = 6'b100011;
        2: fn = 6'b111111;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, 2, -1);
    end

    @(negedge clk); #1;
    chk("final_cnt", 32'(instr_cnt), 32'(retired % (1 << CW)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
